// File: rtl/amul_pkg.sv
// Shared constants and helpers for the pipelined unsigned approximate multiplier.
// Used by both the default build and the AMUL_ERR_MON_EN monitor build.
package amul_pkg;

  localparam int ERR_ACC_W = 32;
  localparam int MAX_N     = 32;

  // Row i of the mask occupies bits [i*MAX_N +: MAX_N]; bit j marks partial product x[i]&y[j].
  typedef logic [MAX_N*MAX_N-1:0] mask_t;

  function automatic mask_t comp_mask(input int n, input int k, input int c);
    mask_t m;
    m = '0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < n; j++) begin
        if (i + j >= c) m[i*MAX_N + j] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [ERR_ACC_W-1:0] sat_add(input logic [ERR_ACC_W-1:0] a,
                                                   input logic [ERR_ACC_W-1:0] b);
    logic [ERR_ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ERR_ACC_W] ? '1 : s[ERR_ACC_W-1:0];
  endfunction

endpackage

// File: rtl/amul_comp_sum.sv
// Combinational sum of the partial-product bits kept in the approximated low rows.
// Only bits with row+column >= C in rows below K contribute; each is summed exactly.
module amul_comp_sum
  import amul_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2,
  parameter int C = 7
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] comp
);

  localparam mask_t MASK = comp_mask(N, K, C);

  // Rows at or above K have an all-zero mask, so they fold away to constants.
  always_comb begin
    comp = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        comp = comp + ({{(2*N-1){1'b0}}, MASK[i*MAX_N + j] & x[i] & y[j]} << (i + j));
      end
    end
  end

endmodule

// File: rtl/unsigned_approx_mul_pipe.sv
// Two-stage valid/ready pipelined unsigned multiplier with truncated low rows.
// Define AMUL_ERR_MON_EN to add an exact shadow datapath and a saturating error accumulator.
module unsigned_approx_mul_pipe
  import amul_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TRUNC_ROWS = 2,
  parameter int KEEP_COL   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z
`ifdef AMUL_ERR_MON_EN
  ,
  input  logic                 err_clr,
  output logic [ERR_ACC_W-1:0] err_acc
`endif
);

  localparam int PW = 2 * WIDTH;

  // Handshake: a transfer happens on a side exactly when valid && ready on that side.
  // in_ready never looks at in_valid; it only depends on stage occupancy and out_ready.
  logic          s1_valid;
  logic          s2_valid;
  logic [PW-1:0] s1_hi;
  logic [PW-1:0] s1_comp;
  logic [PW-1:0] hi_c;
  logic [PW-1:0] comp_c;
  logic [PW-1:0] z_c;
  logic          in_xfer;
  logic          s2_load;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign hi_c = PW'(y) * PW'(x >> TRUNC_ROWS);
  assign z_c  = (s1_hi << TRUNC_ROWS) + s1_comp;

  amul_comp_sum #(
    .N(WIDTH),
    .K(TRUNC_ROWS),
    .C(KEEP_COL)
  ) u_comp (
    .x   (x),
    .y   (y),
    .comp(comp_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hi    <= '0;
      s1_comp  <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_hi    <= hi_c;
      s1_comp  <= comp_c;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // z only changes on a load, so it holds steady while out_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      z        <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      z        <= z_c;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef AMUL_ERR_MON_EN
  localparam int DW = (PW > ERR_ACC_W) ? PW : ERR_ACC_W;

  logic [PW-1:0]        s1_exact;
  logic [PW-1:0]        s2_exact;
  logic [DW-1:0]        diff_w;
  logic [ERR_ACC_W-1:0] err_inc;
  logic                 out_xfer;

  assign out_xfer = s2_valid && out_ready;
  assign diff_w   = DW'(s2_exact - z);
  assign err_inc  = (diff_w > DW'({ERR_ACC_W{1'b1}})) ? '1 : diff_w[ERR_ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exact <= '0;
      s2_exact <= '0;
    end else begin
      if (in_xfer) s1_exact <= PW'(x) * PW'(y);
      if (s2_load) s2_exact <= s1_exact;
    end
  end

  // A clear that coincides with a transfer keeps only that transfer's error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc <= '0;
    end else if (err_clr) begin
      err_acc <= out_xfer ? err_inc : '0;
    end else if (out_xfer) begin
      err_acc <= sat_add(err_acc, err_inc);
    end
  end
`endif

endmodule

// File: tb/tb_unsigned_approx_mul_pipe.sv
// Self-checking bench: approximate (K=2, C=7) and exact (K=0) instances share one stimulus stream.
// Reference model: exact product minus the dropped partial-product bits.
module tb_unsigned_approx_mul_pipe;

  localparam int N  = 8;
  localparam int K  = 2;
  localparam int C  = 7;
  localparam int PW = 2 * N;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] z;
  logic          in_ready_e;
  logic          out_valid_e;
  logic [PW-1:0] z_e;
`ifdef AMUL_ERR_MON_EN
  logic          err_clr;
  logic [31:0]   err_acc;
  logic [31:0]   err_acc_e;
  logic [31:0]   ob_err;
  logic [31:0]   ob_err_e;
`endif

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_e_q[$];

  logic          ob_ir;
  logic          ob_ov;
  logic          ob_ove;
  logic [PW-1:0] ob_z;
  logic [PW-1:0] ob_ze;

  unsigned_approx_mul_pipe #(.WIDTH(N), .TRUNC_ROWS(K), .KEEP_COL(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .z(z)
`ifdef AMUL_ERR_MON_EN
    , .err_clr(err_clr), .err_acc(err_acc)
`endif
  );

  unsigned_approx_mul_pipe #(.WIDTH(N), .TRUNC_ROWS(0), .KEEP_COL(C)) dut_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
    .x(x), .y(y), .out_valid(out_valid_e), .out_ready(out_ready), .z(z_e)
`ifdef AMUL_ERR_MON_EN
    , .err_clr(err_clr), .err_acc(err_acc_e)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] model_z(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input int k);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    for (int i = 0; i < k; i++)
      for (int j = 0; j < N; j++)
        if (i + j < C && a[i] && b[j]) p = p - (PW'(1) << (i + j));
    return p;
  endfunction

`ifdef AMUL_ERR_MON_EN
  function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'(a) + longint'(b);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : a + b;
  endfunction
`endif

  // ---------------- driver ----------------
  // Drives one cycle of inputs, samples outputs before the edge, returns 1 after the edge.
  task automatic step(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic ordy);
    in_valid  = iv;
    x         = a;
    y         = b;
    out_ready = ordy;
    #2;
    ob_ir  = in_ready;
    ob_ov  = out_valid;
    ob_ove = out_valid_e;
    ob_z   = z;
    ob_ze  = z_e;
`ifdef AMUL_ERR_MON_EN
    ob_err   = err_acc;
    ob_err_e = err_acc_e;
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (z !== '0) begin errors++; $display("FAIL reset_z: got %0d expected 0", z); end
`ifdef AMUL_ERR_MON_EN
    checks++; if (err_acc !== '0) begin errors++; $display("FAIL reset_err_acc: got %0d expected 0", err_acc); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    logic [N-1:0]  va[3];
    logic [N-1:0]  vb[3];
    logic [PW-1:0] vz[3];
    va = '{8'hFF, 8'h03, 8'h80};
    vb = '{8'hFF, 8'hFF, 8'h80};
    vz = '{16'd64772, 16'd512, 16'd16384};
    for (int v = 0; v < 3; v++) begin
      step(1'b1, va[v], vb[v], 1'b1);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (ob_ov !== 1'b0) begin errors++; $display("FAIL latency_early v%0d: out_valid got %b expected 0", v, ob_ov); end
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (ob_ov !== 1'b1) begin errors++; $display("FAIL latency_2 v%0d: out_valid got %b expected 1", v, ob_ov); end
      checks++; if (ob_z !== vz[v]) begin errors++; $display("FAIL vector_z v%0d: got %0d expected %0d", v, ob_z, vz[v]); end
      checks++; if (ob_ze !== PW'(va[v]) * PW'(vb[v])) begin errors++; $display("FAIL vector_exact v%0d: got %0d expected %0d", v, ob_ze, PW'(va[v]) * PW'(vb[v])); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  xs[8];
    logic [N-1:0]  ys[8];
    logic [3:0]    pat;
    logic [PW-1:0] e;
    logic [PW-1:0] ee;
    logic [PW-1:0] prev_z;
    logic          prev_stall;
    logic          iv;
    logic          ordy;
    int            sent;
    int            got;
    int            cnt;
    pat = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      xs[i] = 8'($urandom);
      ys[i] = 8'($urandom);
    end
    sent = 0; got = 0; cnt = 0; prev_stall = 1'b0; prev_z = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      ordy = pat[c % 4];
      iv   = (sent < 8);
      step(iv, xs[sent < 8 ? sent : 0], ys[sent < 8 ? sent : 0], ordy);
      checks++; if (ob_ir !== !(cnt == 2 && !ordy)) begin errors++; $display("FAIL b2b_in_ready c%0d: got %b expected %b", c, ob_ir, !(cnt == 2 && !ordy)); end
      if (prev_stall) begin
        checks++; if (ob_ov !== 1'b1 || ob_z !== prev_z) begin errors++; $display("FAIL b2b_hold c%0d: valid=%b z=%0d expected valid=1 z=%0d", c, ob_ov, ob_z, prev_z); end
      end
      if (iv && ob_ir) begin
        exp_q.push_back(model_z(xs[sent], ys[sent], K));
        exp_e_q.push_back(PW'(xs[sent]) * PW'(ys[sent]));
        sent++; cnt++;
      end
      if (ob_ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra c%0d: got z=%0d expected no output", c, ob_z); end
        else begin
          e = exp_q.pop_front(); ee = exp_e_q.pop_front();
          if (ob_z !== e || ob_ze !== ee) begin errors++; $display("FAIL b2b_data #%0d: got %0d/%0d expected %0d/%0d", got, ob_z, ob_ze, e, ee); end
        end
        got++; cnt--;
      end
      prev_stall = ob_ov && !ordy;
      prev_z     = ob_z;
    end
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d results expected 8", got); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (ob_ov !== 1'b0) begin errors++; $display("FAIL b2b_dup: out_valid got %b expected 0", ob_ov); end
    end
    exp_q.delete(); exp_e_q.delete();
  endtask

  task automatic test_random_stream(input int cycles);
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [PW-1:0] e;
    logic [PW-1:0] ee;
    logic [PW-1:0] prev_z;
    logic          prev_stall;
    logic          iv;
    logic          ordy;
    int            cnt;
`ifdef AMUL_ERR_MON_EN
    logic [31:0]   exp_err;
    logic [31:0]   err_i;
    logic          clr;
    err_clr = 1'b1;
    step(1'b0, 8'h00, 8'h00, 1'b0);
    err_clr = 1'b0;
    exp_err = '0;
`endif
    cnt = 0; prev_stall = 1'b0; prev_z = '0;
    for (int c = 0; c < cycles; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      a    = 8'($urandom);
      b    = 8'($urandom);
`ifdef AMUL_ERR_MON_EN
      clr     = ($urandom_range(0, 15) == 0);
      err_clr = clr;
`endif
      step(iv, a, b, ordy);
      checks++; if (ob_ir !== !(cnt == 2 && !ordy)) begin errors++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, ob_ir, !(cnt == 2 && !ordy)); end
      checks++; if (ob_ove !== ob_ov) begin errors++; $display("FAIL rnd_exact_valid c%0d: got %b expected %b", c, ob_ove, ob_ov); end
      if (cnt == 0) begin
        checks++; if (ob_ov !== 1'b0) begin errors++; $display("FAIL rnd_spurious c%0d: out_valid got %b expected 0", c, ob_ov); end
      end
      if (prev_stall) begin
        checks++; if (ob_ov !== 1'b1 || ob_z !== prev_z) begin errors++; $display("FAIL rnd_hold c%0d: valid=%b z=%0d expected valid=1 z=%0d", c, ob_ov, ob_z, prev_z); end
      end
`ifdef AMUL_ERR_MON_EN
      checks++; if (ob_err !== exp_err) begin errors++; $display("FAIL rnd_err_acc c%0d: got %0d expected %0d", c, ob_err, exp_err); end
      checks++; if (ob_err_e !== '0) begin errors++; $display("FAIL rnd_err_acc_exact c%0d: got %0d expected 0", c, ob_err_e); end
      err_i = '0;
`endif
      if (iv && ob_ir) begin
        exp_q.push_back(model_z(a, b, K));
        exp_e_q.push_back(PW'(a) * PW'(b));
        cnt++;
      end
      if (ob_ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra c%0d: got z=%0d expected no output", c, ob_z); end
        else begin
          e = exp_q.pop_front(); ee = exp_e_q.pop_front();
          if (ob_z !== e || ob_ze !== ee) begin errors++; $display("FAIL rnd_data c%0d: got %0d/%0d expected %0d/%0d", c, ob_z, ob_ze, e, ee); end
`ifdef AMUL_ERR_MON_EN
          err_i = 32'(ee - e);
`endif
        end
        cnt--;
      end
`ifdef AMUL_ERR_MON_EN
      if (clr) exp_err = (ob_ov && ordy) ? err_i : '0;
      else if (ob_ov && ordy) exp_err = sat32(exp_err, err_i);
`endif
      prev_stall = ob_ov && !ordy;
      prev_z     = ob_z;
    end
`ifdef AMUL_ERR_MON_EN
    err_clr = 1'b0;
`endif
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      if (ob_ov) begin
        e = exp_q.pop_front(); ee = exp_e_q.pop_front();
        checks++; if (ob_z !== e || ob_ze !== ee) begin errors++; $display("FAIL rnd_drain: got %0d/%0d expected %0d/%0d", ob_z, ob_ze, e, ee); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d results pending expected 0", exp_q.size()); end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    exp_q.delete(); exp_e_q.delete();
  endtask

`ifdef AMUL_ERR_MON_EN
  task automatic test_monitor();
    logic [31:0] unit;
    logic [31:0] expv;
    unit = 32'(16'hFE01 - model_z(8'hFF, 8'hFF, K));
    err_clr = 1'b1;
    step(1'b0, 8'h00, 8'h00, 1'b1);
    err_clr = 1'b0;
    checks++; if (err_acc !== '0) begin errors++; $display("FAIL mon_clear: got %0d expected 0", err_acc); end
    for (int r = 0; r < 4; r++) begin
      step(1'b1, 8'hFF, 8'hFF, 1'b1);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      err_clr = (r == 3);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      err_clr = 1'b0;
      expv = (r == 3) ? unit : unit * 32'(r + 1);
      checks++; if (err_acc !== expv) begin errors++; $display("FAIL mon_acc r%0d: got %0d expected %0d", r, err_acc, expv); end
    end
  endtask
`endif

  task automatic test_reset_midflight();
    step(1'b1, 8'h11, 8'h22, 1'b0);
    step(1'b1, 8'h33, 8'h44, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    checks++; if (ob_ir !== 1'b0 || ob_ov !== 1'b1) begin errors++; $display("FAIL mid_full: in_ready=%b out_valid=%b expected 0/1", ob_ir, ob_ov); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (z !== '0) begin errors++; $display("FAIL mid_z: got %0d expected 0", z); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (ob_ov !== 1'b0 || ob_ove !== 1'b0 || ob_ir !== 1'b1) begin errors++; $display("FAIL mid_stale i%0d: out_valid=%b/%b in_ready=%b expected 0/0/1", i, ob_ov, ob_ove, ob_ir); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
`ifdef AMUL_ERR_MON_EN
    err_clr   = 1'b0;
`endif
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random_stream(4000);
`ifdef AMUL_ERR_MON_EN
    test_monitor();
`endif
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
